// File: rtl/column_feeder_pkg.sv
// Shared types for the column feeder: FILL/RUN state encoding and slot ordering.
// Slot 0 of a column is the oldest (topmost) row; slot HEIGHT_NB-1 is the live pixel.
package column_feeder_pkg;
  typedef enum logic {FILL = 1'b0, RUN = 1'b1} feeder_state_t;
endpackage

// File: rtl/column_feeder_if.sv
// Upstream raster handshake and downstream column bus of the column feeder.
// up_sof exists only when COLUMN_FEEDER_SOF_EN is defined.
interface column_feeder_if #(
  parameter int HEIGHT_NB = 3,
  parameter int IMG_WIDTH = 8
);
  logic [IMG_WIDTH-1:0]           up_pix;
  logic                           up_val;
  logic                           up_rdy;
`ifdef COLUMN_FEEDER_SOF_EN
  logic                           up_sof;
`endif
  logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_img;
  logic                           dn_val;
  logic                           dn_eol;

  modport slave (
`ifdef COLUMN_FEEDER_SOF_EN
    input  up_sof,
`endif
    input  up_pix, up_val,
    output up_rdy, dn_img, dn_val, dn_eol
  );

  modport master (
`ifdef COLUMN_FEEDER_SOF_EN
    output up_sof,
`endif
    output up_pix, up_val,
    input  up_rdy, dn_img, dn_val, dn_eol
  );
endinterface

// File: rtl/column_feeder_line_ram.sv
// One image row of storage: simple dual-port RAM, synchronous read-first read port.
module line_ram #(
  parameter int IMG_WIDTH = 8,
  parameter int IMG_COLS  = 64,
  parameter int AW        = $clog2(IMG_COLS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [IMG_WIDTH-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [IMG_WIDTH-1:0] rdata
);
  logic [IMG_WIDTH-1:0] mem [IMG_COLS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/column_feeder.sv
// Raster-to-column converter: HEIGHT_NB-1 line RAMs in a vertical shift chain, 2-cycle latency.
// Optional COLUMN_FEEDER_SOF_EN adds up_sof frame resynchronisation.
module column_feeder
  import column_feeder_pkg::*;
#(
  parameter int HEIGHT_NB = 3,
  parameter int IMG_WIDTH = 8,
  parameter int IMG_COLS  = 64,
  parameter int COL_WIDTH = $clog2(IMG_COLS)
) (
  input logic             clk,
  input logic             rst,
  column_feeder_if.slave  bus
);
  localparam int ROW_W = $clog2(HEIGHT_NB);
  localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(IMG_COLS - 1);
  localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(HEIGHT_NB - 1);
  localparam logic [ROW_W-1:0]     ROW_PRE  = ROW_W'(HEIGHT_NB - 2);

  feeder_state_t state, state_eff, state_n;
  logic [COL_WIDTH-1:0] col, col_eff, col_s1;
  logic [ROW_W-1:0]     row, row_eff;
  logic                 rdy_q, xfer, sof, wrap, emit, wr_s1;
  logic [IMG_WIDTH-1:0] pix_s1;
  logic [1:0]           vld_pipe;
  logic [HEIGHT_NB-2:0][IMG_WIDTH-1:0] rd;
  logic [HEIGHT_NB*IMG_WIDTH-1:0]      img_n, img_q;
  logic                                eol_q;

  assign bus.up_rdy = rdy_q;
  assign xfer       = bus.up_val & rdy_q;
`ifdef COLUMN_FEEDER_SOF_EN
  assign sof = xfer & bus.up_sof;
`else
  assign sof = 1'b0;
`endif

  // SOF retargets the very transfer that carries it, so it acts on effective counters
  assign col_eff   = sof ? '0 : col;
  assign row_eff   = sof ? '0 : row;
  assign state_eff = sof ? FILL : state;
  assign wrap      = (col_eff == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state_eff;
    if (xfer && wrap && row_eff == ROW_PRE) state_n = RUN;
  end

  always_comb begin
    emit = xfer && (state_eff == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b0;
      col   <= '0;
      row   <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (xfer) begin
        col <= wrap ? '0 : col_eff + 1'b1;
        row <= (wrap && row_eff != ROW_LAST) ? row_eff + 1'b1 : row_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      pix_s1 <= bus.up_pix;
      col_s1 <= col_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_s1    <= 1'b0;
      vld_pipe <= '0;
      eol_q    <= 1'b0;
      img_q    <= '0;
    end else begin
      wr_s1    <= xfer;
      vld_pipe <= {vld_pipe[0], emit};
      eol_q    <= vld_pipe[0] && (col_s1 == COL_LAST);
      if (vld_pipe[0]) img_q <= img_n;
    end
  end

  // RAM k is read at the live column; its write-back one cycle later pushes each row one RAM older
  for (genvar k = 0; k < HEIGHT_NB - 1; k++) begin : g_ram
    logic [IMG_WIDTH-1:0] wd;
    if (k == 0) begin : g_head
      assign wd = pix_s1;
    end else begin : g_chain
      assign wd = rd[k-1];
    end
    line_ram #(.IMG_WIDTH(IMG_WIDTH), .IMG_COLS(IMG_COLS), .AW(COL_WIDTH)) u_ram (
      .clk   (clk),
      .we    (wr_s1),
      .waddr (col_s1),
      .wdata (wd),
      .raddr (col_eff),
      .rdata (rd[k])
    );
  end

  always_comb begin
    img_n = '0;
    img_n[(HEIGHT_NB-1)*IMG_WIDTH +: IMG_WIDTH] = pix_s1;
    for (int h = 0; h < HEIGHT_NB - 1; h++)
      img_n[h*IMG_WIDTH +: IMG_WIDTH] = rd[HEIGHT_NB-2-h];
  end

  assign bus.dn_img = img_q;
  assign bus.dn_val = vld_pipe[1];
  assign bus.dn_eol = eol_q;
endmodule
